funct_generator_wave: RTL and testbench
=======================================

# funct_generator_wave

Three-channel waveform source for the function generator datapath, sitting directly upstream of the three-input adder stage. On each accepted sample tick it advances a sawtooth, a triangle and a square channel and presents them as registered samples with a one-cycle `valid_o` strobe. That strobe drives the adder's `enh`, and `clrh` is shared with the adder.

## Interface
Clock is `clk`. Reset is `rsth`, asynchronous and active-high.

Parameters:
- `DATA_WIDTH`, 8, sample width of every channel and of all amplitude/step inputs.
- `STEP_WIDTH`, 8, width of the square half-period count.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rsth`  in  1  asynchronous active-high reset.
- `clrh`  in  1  synchronous clear of all channel state; highest priority after reset.
- `enh`  in  1  run enable; `tick_i` is ignored while low.
- `tick_i`  in  1  sample strobe; one channel advance per accepted cycle.
- `step_a_i`  in  DATA_WIDTH  sawtooth increment.
- `step_b_i`  in  DATA_WIDTH  triangle increment/decrement.
- `half_c_i`  in  STEP_WIDTH  square half-period, in accepted ticks; 0 is treated as 1.
- `amp_c_i`  in  DATA_WIDTH  square high level.
- `data_a_o`  out  DATA_WIDTH  sawtooth sample.
- `data_b_o`  out  DATA_WIDTH  triangle sample.
- `data_c_o`  out  DATA_WIDTH  square sample.
- `valid_o`  out  1  one-cycle pulse marking new samples.

## Operation
- Accepted tick: `enh & tick_i & ~clrh`.
- MAX is 2^DATA_WIDTH-1.
- Sawtooth: on an accepted tick, `saw <= saw + step_a_i`, modulo 2^DATA_WIDTH (wraps silently).
- Triangle uses two states, TRI_UP and TRI_DOWN. Arithmetic is done in DATA_WIDTH+1 bits.
  - TRI_UP: if `tri + step_b_i >= MAX`, then `tri <= MAX` and go to TRI_DOWN. Otherwise add.
  - TRI_DOWN: if `tri <= step_b_i`, then `tri <= 0` and go to TRI_UP. Otherwise subtract.
  - Step 0 holds the value; the state never changes.
- Square: counter `cnt` (STEP_WIDTH) and a 1-bit `level`.
  - On an accepted tick: if `cnt >= max(half_c_i,1)-1`, then `cnt <= 0` and `level` toggles. Otherwise `cnt++`.
  - `data_c_o` is registered as `level ? amp_c_i : 0`, computed from the post-update level.
- Input changes (step, half, amp) take effect at the next accepted tick; no channel restarts.
  - Shrinking `half_c_i` below the current `cnt` toggles `level` on the next tick.
- `clrh`: all channel state returns to its reset values at the next edge; `valid_o` is 0 that cycle.
- `clrh` and `tick_i` in the same cycle: clear wins and the tick is dropped.

## Timing
- Reset values: `data_a_o`/`data_b_o`/`data_c_o` = 0, `valid_o` = 0, triangle state TRI_UP, `cnt` = 0, `level` = 0.
- Reset takes effect immediately, mid-operation included.
- Latency is 1 cycle. An accepted tick at edge N produces updated outputs and `valid_o`=1 after edge N+1.
- `valid_o` is high for exactly one cycle per accepted tick.
  - Back-to-back ticks keep it high continuously, with new samples every cycle.
- Outputs hold between ticks and while `enh`=0.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- `funct_generator_pkg`:
  - `tri_state_t` enum {TRI_UP, TRI_DOWN}.
  - Default `DATA_WIDTH`/`STEP_WIDTH` localparams.
  - Shared accepted-tick helper function.
- Sub-module `funct_generator_tri`: the triangle channel, holding its state machine and saturation arithmetic.
  - It takes `clk`, `rsth`, `clrh`, accepted tick and step, and returns the sample.
- The sawtooth and square channels and the `valid_o` register live in the top module.

## Test plan
All values use DATA_WIDTH=8.
- Async reset mid-run: assert `rsth` while samples are nonzero -> all outputs 0 and `valid_o`=0 before the next edge; first accepted tick after release gives sawtooth = `step_a_i`.
- Sawtooth wrap: `step_a_i`=0x60, 3 ticks -> 0x60, 0xC0, 0x20.
- Triangle reversal: `step_b_i`=0x70, 7 ticks -> 0x70, 0xE0, 0xFF, 0x8F, 0x1F, 0x00, 0x70.
- Square: `half_c_i`=2, `amp_c_i`=0xA5, 6 ticks -> 0x00, 0xA5, 0xA5, 0x00, 0x00, 0xA5.
- Square with `half_c_i`=0 -> output toggles on every tick.
- Gating: `enh`=0 with ticks -> outputs unchanged, `valid_o` stays 0.
- Gating: `clrh`=1 coincident with a tick -> all outputs 0 next cycle, `valid_o`=0.
- Throughput: `tick_i` held high 5 cycles with `step_a_i`=1 -> `valid_o` high 5 consecutive cycles, sawtooth 1..5.

Source files
------------

// File: rtl/funct_generator_pkg.sv
// rtl/funct_generator_pkg.sv - shared types, default widths and tick qualification
// for the three-channel waveform source.
package funct_generator_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_STEP_WIDTH = 8;

  typedef enum logic [0:0] {
    TRI_UP   = 1'b0,
    TRI_DOWN = 1'b1
  } tri_state_t;

  // A clear in the same cycle swallows the tick, so every channel sees the same rule.
  function automatic logic accept_tick(
    input logic enh,
    input logic tick,
    input logic clrh
  );
    return enh & tick & ~clrh;
  endfunction

endpackage

// File: rtl/funct_generator_tri.sv
// rtl/funct_generator_tri.sv - triangle channel: up/down ramp that saturates at
// MAX and 0 and reverses there.
module funct_generator_tri
  import funct_generator_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rsth,
  input  logic                  clrh,
  input  logic                  accept_i,
  input  logic [DATA_WIDTH-1:0] step_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam logic [DATA_WIDTH:0]   MAX_WIDE = {1'b0, {DATA_WIDTH{1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MAX_VAL  = {DATA_WIDTH{1'b1}};

  tri_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] tri_val_q, tri_val_d;
  logic [DATA_WIDTH:0]   sum_wide;
  logic                  step_zero;

  assign sum_wide  = {1'b0, tri_val_q} + {1'b0, step_i};
  assign step_zero = (step_i == '0);

  always_comb begin
    tri_val_d = tri_val_q;
    state_d   = state_q;
    if (clrh) begin
      tri_val_d = '0;
      state_d   = TRI_UP;
    end else if (accept_i && !step_zero) begin
      // Zero step is excluded above so the ramp can never flip direction while parked.
      case (state_q)
        TRI_UP: begin
          if (sum_wide >= MAX_WIDE) begin
            tri_val_d = MAX_VAL;
            state_d   = TRI_DOWN;
          end else begin
            tri_val_d = sum_wide[DATA_WIDTH-1:0];
          end
        end
        TRI_DOWN: begin
          if (tri_val_q <= step_i) begin
            tri_val_d = '0;
            state_d   = TRI_UP;
          end else begin
            tri_val_d = tri_val_q - step_i;
          end
        end
        default: begin
          tri_val_d = '0;
          state_d   = TRI_UP;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rsth) begin
    if (rsth) begin
      tri_val_q <= '0;
      state_q   <= TRI_UP;
    end else begin
      tri_val_q <= tri_val_d;
      state_q   <= state_d;
    end
  end

  assign data_o = tri_val_q;

endmodule

// File: rtl/funct_generator_wave.sv
// rtl/funct_generator_wave.sv - three-channel waveform source (sawtooth, triangle,
// square) with registered samples and a one-cycle valid strobe.
module funct_generator_wave
  import funct_generator_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int STEP_WIDTH = DEFAULT_STEP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rsth,
  input  logic                  clrh,
  input  logic                  enh,
  input  logic                  tick_i,
  input  logic [DATA_WIDTH-1:0] step_a_i,
  input  logic [DATA_WIDTH-1:0] step_b_i,
  input  logic [STEP_WIDTH-1:0] half_c_i,
  input  logic [DATA_WIDTH-1:0] amp_c_i,
  output logic [DATA_WIDTH-1:0] data_a_o,
  output logic [DATA_WIDTH-1:0] data_b_o,
  output logic [DATA_WIDTH-1:0] data_c_o,
  output logic                  valid_o
);

  localparam logic [STEP_WIDTH-1:0] CNT_ONE = {{(STEP_WIDTH-1){1'b0}}, 1'b1};

  logic                  accept;
  logic [DATA_WIDTH-1:0] saw_q, saw_d;
  logic [STEP_WIDTH-1:0] cnt_q, cnt_d;
  logic                  level_q, level_d;
  logic [DATA_WIDTH-1:0] data_c_q, data_c_d;
  logic                  valid_q, valid_d;
  logic [STEP_WIDTH-1:0] half_eff;
  logic [STEP_WIDTH-1:0] cnt_limit;

  assign accept    = accept_tick(enh, tick_i, clrh);
  assign half_eff  = (half_c_i == '0) ? CNT_ONE : half_c_i;
  assign cnt_limit = half_eff - CNT_ONE;

  always_comb begin
    saw_d    = saw_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    data_c_d = data_c_q;
    valid_d  = 1'b0;
    if (clrh) begin
      saw_d    = '0;
      cnt_d    = '0;
      level_d  = 1'b0;
      data_c_d = '0;
    end else if (accept) begin
      valid_d = 1'b1;
      saw_d   = saw_q + step_a_i;
      // >= rather than == so a shrunken half-period toggles on the very next tick.
      if (cnt_q >= cnt_limit) begin
        cnt_d   = '0;
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
      data_c_d = level_d ? amp_c_i : '0;
    end
  end

  always_ff @(posedge clk or posedge rsth) begin
    if (rsth) begin
      saw_q    <= '0;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      data_c_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      saw_q    <= saw_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      data_c_q <= data_c_d;
      valid_q  <= valid_d;
    end
  end

  funct_generator_tri #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_tri (
    .clk     (clk),
    .rsth    (rsth),
    .clrh    (clrh),
    .accept_i(accept),
    .step_i  (step_b_i),
    .data_o  (data_b_o)
  );

  assign data_a_o = saw_q;
  assign data_c_o = data_c_q;
  assign valid_o  = valid_q;

endmodule

// File: tb/tb_funct_generator_wave.sv
// tb/tb_funct_generator_wave.sv - directed table-driven bench for funct_generator_wave.
module tb_funct_generator_wave;

  logic       clk = 1'b0;
  logic       rsth, clrh, enh, tick_i;
  logic [7:0] step_a_i, step_b_i, half_c_i, amp_c_i;
  logic [7:0] data_a_o, data_b_o, data_c_o;
  logic       valid_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       enh;
    logic       tick;
    logic       clr;
    logic [7:0] sa;
    logic [7:0] sb;
    logic [7:0] hc;
    logic [7:0] ac;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] ec;
    logic       ev;
  } vec_t;

  vec_t vecs [16];

  funct_generator_wave dut (
    .clk     (clk),
    .rsth    (rsth),
    .clrh    (clrh),
    .enh     (enh),
    .tick_i  (tick_i),
    .step_a_i(step_a_i),
    .step_b_i(step_b_i),
    .half_c_i(half_c_i),
    .amp_c_i (amp_c_i),
    .data_a_o(data_a_o),
    .data_b_o(data_b_o),
    .data_c_o(data_c_o),
    .valid_o (valid_o)
  );

  always #5 clk = ~clk;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                           input logic [7:0] ec, input logic ev);
    check8({tag, " data_a"}, data_a_o, ea);
    check8({tag, " data_b"}, data_b_o, eb);
    check8({tag, " data_c"}, data_c_o, ec);
    check8({tag, " valid"}, {7'd0, valid_o}, {7'd0, ev});
  endtask

  initial begin
    //          enh   tick  clr   sa     sb     hc     ac     ea     eb     ec     ev
    vecs[0]  = {1'b1, 1'b1, 1'b0, 8'h60, 8'h70, 8'h02, 8'hA5, 8'h60, 8'h70, 8'h00, 1'b1};
    vecs[1]  = {1'b1, 1'b1, 1'b0, 8'h60, 8'h70, 8'h02, 8'hA5, 8'hC0, 8'hE0, 8'hA5, 1'b1};
    vecs[2]  = {1'b1, 1'b1, 1'b0, 8'h60, 8'h70, 8'h02, 8'hA5, 8'h20, 8'hFF, 8'hA5, 1'b1};
    vecs[3]  = {1'b1, 1'b1, 1'b0, 8'h60, 8'h70, 8'h02, 8'hA5, 8'h80, 8'h8F, 8'h00, 1'b1};
    vecs[4]  = {1'b1, 1'b1, 1'b0, 8'h60, 8'h70, 8'h02, 8'hA5, 8'hE0, 8'h1F, 8'h00, 1'b1};
    vecs[5]  = {1'b1, 1'b1, 1'b0, 8'h60, 8'h70, 8'h02, 8'hA5, 8'h40, 8'h00, 8'hA5, 1'b1};
    vecs[6]  = {1'b1, 1'b1, 1'b0, 8'h60, 8'h70, 8'h02, 8'hA5, 8'hA0, 8'h70, 8'hA5, 1'b1};
    vecs[7]  = {1'b1, 1'b0, 1'b0, 8'h60, 8'h70, 8'h02, 8'hA5, 8'hA0, 8'h70, 8'hA5, 1'b0};
    vecs[8]  = {1'b0, 1'b1, 1'b0, 8'h60, 8'h70, 8'h02, 8'hA5, 8'hA0, 8'h70, 8'hA5, 1'b0};
    vecs[9]  = {1'b1, 1'b1, 1'b1, 8'h60, 8'h70, 8'h02, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[10] = {1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 8'h00, 8'h3C, 8'h01, 8'h00, 8'h3C, 1'b1};
    vecs[11] = {1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 8'h00, 8'h3C, 8'h02, 8'h00, 8'h00, 1'b1};
    vecs[12] = {1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 8'h00, 8'h3C, 8'h03, 8'h00, 8'h3C, 1'b1};
    vecs[13] = {1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 8'h05, 8'h11, 8'h04, 8'h00, 8'h11, 1'b1};
    vecs[14] = {1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 8'h05, 8'h11, 8'h05, 8'h00, 8'h11, 1'b1};
    vecs[15] = {1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 8'h01, 8'h11, 8'h06, 8'h00, 8'h00, 1'b1};

    rsth = 1'b1; clrh = 1'b0; enh = 1'b0; tick_i = 1'b0;
    step_a_i = 8'h00; step_b_i = 8'h00; half_c_i = 8'h00; amp_c_i = 8'h00;
    #12;
    check_all("reset", 8'h00, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    rsth = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      enh      = vecs[i].enh;
      tick_i   = vecs[i].tick;
      clrh     = vecs[i].clr;
      step_a_i = vecs[i].sa;
      step_b_i = vecs[i].sb;
      half_c_i = vecs[i].hc;
      amp_c_i  = vecs[i].ac;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].ec, vecs[i].ev);
    end

    // Throughput: tick held high for five edges after a clear.
    tick_i = 1'b0; clrh = 1'b1;
    @(posedge clk);
    #1;
    clrh = 1'b0; enh = 1'b1; step_a_i = 8'h01; step_b_i = 8'h00; tick_i = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      check8($sformatf("burst%0d data_a", k), data_a_o, 8'(k));
      check8($sformatf("burst%0d valid", k), {7'd0, valid_o}, 8'h01);
    end
    tick_i = 1'b0;
    @(posedge clk);
    #1;
    check8("burst end valid", {7'd0, valid_o}, 8'h00);
    check8("burst end hold", data_a_o, 8'h05);

    // Async reset between edges while samples are live.
    tick_i = 1'b1;
    @(posedge clk);
    #1;
    check8("pre-reset data_a", data_a_o, 8'h06);
    tick_i = 1'b0;
    #1;
    rsth = 1'b1;
    #1;
    check_all("async reset", 8'h00, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    rsth = 1'b0; step_a_i = 8'h33; tick_i = 1'b1;
    @(posedge clk);
    #1;
    check_all("post-reset", 8'h33, 8'h00, 8'h11, 1'b1);
    tick_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
